ir_trace_buffer: RTL
====================

Name: ir_trace_buffer

Overview:
Parametrised on-chip capture buffer for the processor's instruction-register opcode and memory data-in bus. It supersedes per-cycle $display printing with a synthesizable trace FIFO. The buffer offers continuous, fill-and-stop and opcode-triggered capture modes, plus an optional change-only filter. It sits beside the processor core, taps ir_out/datain1 and is drained by a bench or debug reader through a pop interface.

Parameters:
OP_W, 4, opcode (IR) width
DATA_W, 16, memory data-in width
DEPTH, 16, entries; power of two, >=2
CHANGE_ONLY, 0, 1 = store a sample only if {ir_in,data_in} differs from the last stored sample

Ports:
CLOCK_50  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; begin capture per mode (accepted only in IDLE)
stop  in  1  pulse; end capture, go DONE
clear  in  1  pulse; flush buffer, clear flags, go IDLE
mode  in  2  0 off, 1 continuous-wrap, 2 fill-and-stop, 3 triggered; sampled on start
trig_opcode  in  OP_W  trigger match value for mode 3
ir_in  in  OP_W  opcode from IR
data_in  in  DATA_W  memory data-in bus
rd_en  in  1  pop request
rd_valid  out  1  rd_ir/rd_data valid this cycle
rd_ir  out  OP_W  popped opcode
rd_data  out  DATA_W  popped data
count  out  $clog2(DEPTH+1)  stored entries
full  out  1  count==DEPTH
empty  out  1  count==0
state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
triggered  out  1  sticky: trigger hit since last start
overflow  out  1  sticky: entry overwritten in mode 1

Behaviour:
- Reset: state=IDLE, pointers=0, count=0, empty=1, full=0, rd_valid=0, rd_ir=0, rd_data=0, triggered=0, overflow=0. Reset mid-capture discards all contents.
- Priority per cycle: clear > stop > start > sampling.
- IDLE: start with mode 1/2 -> CAPTURE; start with mode 3 -> ARMED; start with mode 0 ignored. start clears triggered/overflow but not contents.
- ARMED: when ir_in==trig_opcode, store that same-cycle sample as an entry (subject to full, below), set triggered, go CAPTURE and behave as mode 2 thereafter. No entries are stored while ARMED and unmatched.
- CAPTURE: on each cycle a sample qualifies, write {ir_in,data_in} at the write pointer.
- A sample qualifies when CHANGE_ONLY=0, or the buffer has had no write since clear/reset, or {ir_in,data_in} differs from the last written pair.
- Mode 1 full, qualifying write, no pop: overwrite the oldest entry, advance the read pointer, count stays DEPTH, set overflow.
- Mode 2/3 full: no write; state -> DONE the same cycle full is observed with a qualifying sample, or the cycle after the write that makes count==DEPTH (whichever is first; an implementation must go DONE no later than the cycle after full rises).
- stop in ARMED/CAPTURE -> DONE. DONE holds until clear. start is ignored outside IDLE.
- Read: rd_en && !empty pops the oldest entry. rd_ir/rd_data are registered; rd_valid=1 on the following cycle and deasserts otherwise. rd_en while empty is ignored (rd_valid=0). Reads are allowed in every state.
- Simultaneous write and pop: both occur and count is unchanged. In mode 1 when full, a simultaneous pop prevents the overwrite, so overflow is not set.
- Pointers wrap modulo DEPTH. count is exact and never exceeds DEPTH.
- clear: pointers=0, count=0, flags=0, rd_valid=0 next cycle, the CHANGE_ONLY history is invalidated, state=IDLE.

Test Plan:
- DEPTH=4, mode 2, start, ir_in=1,2,3,4,5 on consecutive cycles -> count=4, full=1, state=DONE; pops return ir 1,2,3,4 with rd_valid one cycle after each rd_en, then empty=1.
- mode 1, DEPTH=4, 6 samples ir 1..6, no reads -> overflow=1, count=4; pops return 3,4,5,6.
- mode 3, trig_opcode=4'b1010, ir_in sequence 1,5,A,B,C,D,E -> nothing stored before A, triggered=1; pops return A,B,C,D; state=DONE.
- CHANGE_ONLY=1, mode 2, samples (1,0x0010),(1,0x0010),(2,0x0010),(2,0x0011) -> count=3.
- Full in mode 1 with rd_en and a new sample in the same cycle -> count stays 4, overflow=0, oldest entry returned.
- Assert reset mid-CAPTURE with count=3 -> count=0, empty=1, state=IDLE, rd_valid=0 immediately. Then clear while DONE -> state=IDLE, flags=0.

Source files
------------

// File: rtl/ir_trace_buffer.sv
// ir_trace_buffer: capture FIFO for IR opcode and memory data-in
// Supports continuous-wrap, fill-and-stop and opcode-triggered capture with an optional change-only filter.
module ir_trace_buffer #(
    parameter int OP_W        = 4,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 16,
    parameter bit CHANGE_ONLY = 1'b0
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       clear,
    input  logic [1:0]                 mode,
    input  logic [OP_W-1:0]            trig_opcode,
    input  logic [OP_W-1:0]            ir_in,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [OP_W-1:0]            rd_ir,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic [1:0]                 state,
    output logic                       triggered,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = OP_W + DATA_W;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t        st, st_nxt;
    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] last_pair;
    logic [PW-1:0] pair;
    logic          last_valid, cap_wrap;
    logic          pop, wr, start_ok, set_trig, qual, overwrite;

    assign pair      = {ir_in, data_in};
    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;
    assign state     = st;
    assign pop       = rd_en && !empty && !clear;
    assign qual      = !CHANGE_ONLY || !last_valid || pair != last_pair;
    // a write into a full wrap-mode buffer without a pop evicts the oldest entry
    assign overwrite = wr && full && !pop;

    always_comb begin
        st_nxt   = st;
        wr       = 1'b0;
        start_ok = 1'b0;
        set_trig = 1'b0;
        if (clear)
            st_nxt = IDLE;
        else if (stop)
            st_nxt = (st == ARMED || st == CAPTURE) ? DONE : st;
        else
            case (st)
                IDLE: begin
                    start_ok = start && mode != 2'd0;
                    st_nxt   = !start_ok ? IDLE : (mode == 2'd3) ? ARMED : CAPTURE;
                end
                ARMED: begin
                    set_trig = ir_in == trig_opcode;
                    wr       = set_trig && qual && !full;
                    st_nxt   = !set_trig ? ARMED : full ? DONE : CAPTURE;
                end
                CAPTURE: begin
                    wr     = qual && (cap_wrap || !full);
                    st_nxt = (!cap_wrap && full) ? DONE : CAPTURE;
                end
                default: st_nxt = st;
            endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            st         <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_valid   <= 1'b0;
            rd_ir      <= '0;
            rd_data    <= '0;
            triggered  <= 1'b0;
            overflow   <= 1'b0;
            last_valid <= 1'b0;
            last_pair  <= '0;
            cap_wrap   <= 1'b0;
        end else begin
            st       <= st_nxt;
            rd_valid <= pop;
            if (pop)
                {rd_ir, rd_data} <= mem[rd_ptr];
            if (clear) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                triggered  <= 1'b0;
                overflow   <= 1'b0;
                last_valid <= 1'b0;
            end else begin
                if (start_ok) begin
                    triggered <= 1'b0;
                    overflow  <= 1'b0;
                    cap_wrap  <= mode == 2'd1;
                end
                if (set_trig)
                    triggered <= 1'b1;
                if (overwrite)
                    overflow <= 1'b1;
                if (wr) begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    last_pair  <= pair;
                    last_valid <= 1'b1;
                end
                if (pop || overwrite)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(wr && !overwrite) - CW'(pop);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr)
            mem[wr_ptr] <= pair;
    end

endmodule
